// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit with MIPS-style HI/LO result registers.
// One bit per cycle: shift-add multiply, restoring divide, sign fix-up last.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             flush,
  input  logic [WIDTH-1:0] portA,
  input  logic [WIDTH-1:0] portB,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divzero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CNTW-1:0]  cnt;
  logic [WIDTH-1:0] hacc;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic             is_div;
  logic             neg_res;
  logic             neg_rem;
  logic             dz_pend;

  logic             op_div;
  logic             op_sgn;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH-1:0] div_sub;
  logic             div_ok;

  logic [WIDTH-1:0]   hacc_n;
  logic [WIDTH-1:0]   areg_n;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign ready  = (state == S_IDLE);
  assign op_div = op[1];
  assign op_sgn = op[0];

  always_comb begin
    a_abs = portA;
    b_abs = portB;
    if (op_sgn && portA[WIDTH-1]) a_abs = -portA;
    if (op_sgn && portB[WIDTH-1]) b_abs = -portB;
  end

  // Multiply: {hacc,areg} shifts right, breg is the multiplicand.
  // Divide: hacc is the partial remainder, areg shifts dividend
  // bits out the top and quotient bits in at the bottom.
  always_comb begin
    mul_sum = {1'b0, hacc} + (areg[0] ? {1'b0, breg} : '0);
    div_sh  = {hacc, areg[WIDTH-1]};
    div_ok  = (div_sh >= {1'b0, breg});
    div_sub = div_sh[WIDTH-1:0] - breg;
    hacc_n  = hacc;
    areg_n  = areg;
    if (is_div) begin
      hacc_n = div_ok ? div_sub : div_sh[WIDTH-1:0];
      areg_n = {areg[WIDTH-2:0], div_ok};
    end else begin
      hacc_n = mul_sum[WIDTH:1];
      areg_n = {mul_sum[0], areg[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_fix = {hacc, areg};
    quo_fix  = areg;
    rem_fix  = hacc;
    if (neg_res) begin
      prod_fix = -{hacc, areg};
      quo_fix  = -areg;
    end
    if (neg_rem) rem_fix = -hacc;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      cnt     <= '0;
      hacc    <= '0;
      areg    <= '0;
      breg    <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz_pend <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      divzero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start && !flush) begin
            hacc    <= '0;
            areg    <= a_abs;
            breg    <= b_abs;
            is_div  <= op_div;
            neg_res <= op_sgn & (portA[WIDTH-1] ^ portB[WIDTH-1]);
            neg_rem <= op_sgn & op_div & portA[WIDTH-1];
            dz_pend <= op_div & (portB == '0);
            cnt     <= '0;
            state   <= S_CALC;
          end
        end
        S_CALC: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            hacc <= hacc_n;
            areg <= areg_n;
            cnt  <= cnt + 1'b1;
            if (cnt == LAST) state <= S_FIX;
          end
        end
        S_FIX: begin
          state <= S_IDLE;
          if (!flush) begin
            done    <= 1'b1;
            divzero <= dz_pend;
            if (is_div) begin
              hi <= rem_fix;
              lo <= dz_pend ? '1 : quo_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised multi-cycle multiply/divide unit alongside the single-cycle ALU in the execute stage.
- Accepts signed/unsigned multiply and divide. Computes iteratively, one bit per cycle (shift-add multiply, restoring divide).
- Results are held in HI/LO registers with MIPS semantics.
- The pipeline stalls on ready=0 and consumes results on the done pulse.

Parameters:
- WIDTH, 32, operand and result width in bits (≥4). HI and LO are each WIDTH bits.
- CNTW, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- CLK  in  1  clock, all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when ready=1.
- op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- flush  in  1  abort the in-flight operation (pipeline squash).
- portA  in  WIDTH  multiplicand / dividend; sampled with start.
- portB  in  WIDTH  multiplier / divisor; sampled with start.
- ready  out  1  unit idle; a start will be accepted this cycle.
- done  out  1  single-cycle pulse; hi/lo/divzero are valid and updated.
- hi  out  WIDTH  product upper half / remainder.
- lo  out  WIDTH  product lower half / quotient.
- divzero  out  1  last completed op was a divide with portB=0; held until the next completion.

Behaviour:
- Reset (RST=1 at an edge, any state): state=IDLE, ready=1, done=0, hi=0, lo=0, divzero=0, internal registers cleared. Reset mid-operation discards the operation with no done pulse.
- States:
  - IDLE: ready=1. start=1 and flush=0 → latch op and operands, take absolute values for signed ops, record result signs, counter=0, go to CALC.
  - CALC: ready=0. One iteration per cycle for exactly WIDTH cycles. The counter increments each cycle; when counter=WIDTH-1 go to FIX.
  - FIX: ready=0. Apply two's-complement sign correction, write hi/lo/divzero, assert done on the following cycle, go to IDLE.
- Latency: start sampled at edge 0 → done=1 in the cycle after edge WIDTH+1, i.e. WIDTH+2 cycles. The count is fixed regardless of operand values.
- done cycle: state is IDLE and ready=1, so a back-to-back start in the done cycle is accepted.
- start while ready=0 is ignored; operand ports are don't-care outside the start cycle.
- flush:
  - In CALC or FIX: return to IDLE at the next edge. No done pulse; hi/lo/divzero keep their previous values.
  - In IDLE with start: flush wins and start is ignored.
- Multiply: 2·WIDTH-bit product, hi=upper, lo=lower.
  - MULT: product negative iff operand signs differ.
  - MULTU: operands are unsigned.
- Divide: lo=quotient, hi=remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero (DIV/DIVU, portB=0): full latency still applies. Result is lo=all ones, hi=portA (unmodified dividend), divzero=1. Any non-divzero completion clears divzero.
- Signed overflow (DIV, MIN/−1): lo=MIN (0x80000000 at WIDTH=32), hi=0, divzero=0.
- hi/lo change only on a completed op or on reset.

Test Plan:
1. WIDTH=32, MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001, done exactly 34 cycles after the start edge, ready=0 throughout.
2. MULT −3×7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000×0x80000000 → hi=0x40000000, lo=0.
3. DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 → lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
4. DIVU 5/0 → lo=0xFFFFFFFF, hi=5, divzero=1. A following MULTU 2×3 clears divzero, giving hi=0, lo=6.
5. Flush and ignored start:
   - flush 10 cycles into CALC → no done, hi/lo equal the prior result, ready=1 next cycle.
   - start asserted while busy → ignored.
   - start+flush together in IDLE → no operation.
6. Reset and back-to-back:
   - RST asserted mid-CALC → next edge: ready=1, hi=lo=0, done=0.
   - Second start issued in the done cycle → second result arrives after another 34 cycles.
